// File: rtl/kiwi_objbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kiwi_objbank_arbiter
// Purpose  : Banked object-field store shared by two requesters. Logical
//            handles are translated through a swappable handle table, and
//            requesters are arbitrated round-robin. A pending swap command
//            takes priority over both requesters.
// Options  : define KIWI_OBJBANK_STATS_EN to add the saturating
//            conflict_cnt and swap_cnt statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module kiwi_objbank_arbiter #(
  parameter int NOBJ   = 2,
  parameter int NFIELD = 4,
  parameter int DW     = 32,
  parameter int HW     = 1,
  parameter int FW     = 2
) (
  input  logic          clk,
  input  logic          reset,
  // requester 0
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [HW-1:0] r0_handle,
  input  logic [FW-1:0] r0_field,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  // requester 1
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [HW-1:0] r1_handle,
  input  logic [FW-1:0] r1_field,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  // handle swap command
  input  logic          swap_req,
  input  logic [HW-1:0] swap_a,
  input  logic [HW-1:0] swap_b,
  output logic          swap_done,
`ifdef KIWI_OBJBANK_STATS_EN
  output logic [15:0]   conflict_cnt,
  output logic [15:0]   swap_cnt,
`endif
  output logic          busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SWAP = 1'b1
  } state_t;

  // NFIELD never exceeds 2**FW, so it fits in FW+1 bits for the range check.
  localparam logic [FW:0] c_NFIELD = (FW+1)'(NFIELD);

  state_t        r_state;
  logic          r_busy;
  logic          r_swap_done;
  logic          r_last;
  logic [HW-1:0] r_map [NOBJ];
  logic [DW-1:0] r_mem [NOBJ][NFIELD];
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_idle;
  logic          w_swap_take;
  logic          w_arb;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [HW-1:0] w_phys0;
  logic [HW-1:0] w_phys1;
  logic          w_f0_ok;
  logic          w_f1_ok;
  logic [DW-1:0] w_rd0;
  logic [DW-1:0] w_rd1;

  // The swap requester keeps swap_req high until it observes swap_done, so
  // the acknowledge cycle must not start a second swap.
  assign w_idle      = (r_state == S_IDLE);
  assign w_swap_take = swap_req & ~r_swap_done;
  assign w_arb       = w_idle & ~w_swap_take;

  // Tie goes to whoever did not win last; grants never look at data inputs.
  assign w_gnt0 = w_arb & r0_req & (~r1_req |  r_last);
  assign w_gnt1 = w_arb & r1_req & (~r0_req | ~r_last);

  // Handle translation uses the table as it stands before this clock edge.
  assign w_phys0 = r_map[r0_handle];
  assign w_phys1 = r_map[r1_handle];
  assign w_f0_ok = ({1'b0, r0_field} < c_NFIELD);
  assign w_f1_ok = ({1'b0, r1_field} < c_NFIELD);
  assign w_rd0   = w_f0_ok ? r_mem[w_phys0][r0_field] : '0;
  assign w_rd1   = w_f1_ok ? r_mem[w_phys1][r1_field] : '0;

  // Control FSM: one-cycle swap state with atomic handle-table exchange.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_swap_done <= 1'b0;
      for (int i = 0; i < NOBJ; i++) begin
        r_map[i] <= HW'(i);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_swap_done <= 1'b0;
          if (w_swap_take) begin
            r_state <= S_SWAP;
            r_busy  <= 1'b1;
          end
        end
        S_SWAP: begin
          // Both sides read the old table, so swap_a == swap_b is a no-op.
          r_map[swap_a] <= r_map[swap_b];
          r_map[swap_b] <= r_map[swap_a];
          r_swap_done   <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_swap_done <= 1'b0;
        end
      endcase
    end
  end

  // Field storage: granted writes land at the edge, out-of-range fields drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NOBJ; i++) begin
        for (int j = 0; j < NFIELD; j++) begin
          r_mem[i][j] <= '0;
        end
      end
    end else begin
      if (w_gnt0 && r0_we && w_f0_ok) begin
        r_mem[w_phys0][r0_field] <= r0_wdata;
      end
      if (w_gnt1 && r1_we && w_f1_ok) begin
        r_mem[w_phys1][r1_field] <= r1_wdata;
      end
    end
  end

  // Round-robin history and registered read return (latency 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      if (w_gnt0) begin
        r_last <= 1'b0;
      end else if (w_gnt1) begin
        r_last <= 1'b1;
      end
      r_rvalid0 <= w_gnt0 & ~r0_we;
      r_rvalid1 <= w_gnt1 & ~r1_we;
      if (w_gnt0 && !r0_we) begin
        r_rdata0 <= w_rd0;
      end
      if (w_gnt1 && !r1_we) begin
        r_rdata1 <= w_rd1;
      end
    end
  end

`ifdef KIWI_OBJBANK_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_swap_cnt;
  logic        w_conflict;

  assign w_conflict = w_idle & ((r0_req & r1_req) | ((r0_req | r1_req) & swap_req));

  // Saturating statistics counters; swap_cnt steps with each swap commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict_cnt <= '0;
      r_swap_cnt     <= '0;
    end else begin
      if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
      if ((r_state == S_SWAP) && (r_swap_cnt != 16'hFFFF)) begin
        r_swap_cnt <= r_swap_cnt + 16'd1;
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign swap_cnt     = r_swap_cnt;
`endif

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign r0_rvalid = r_rvalid0;
  assign r1_rvalid = r_rvalid1;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign swap_done = r_swap_done;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_kiwi_objbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kiwi_objbank_arbiter
// Purpose  : Self-checking bench for kiwi_objbank_arbiter. A reference model
//            tracks the handle table, field store and arbitration history;
//            read returns are queued when issued and popped on return.
//            A second instance with NFIELD=3 covers the field range check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kiwi_objbank_arbiter;

  localparam int NOBJ   = 2;
  localparam int NFIELD = 4;
  localparam int DW     = 32;
  localparam int HW     = 1;
  localparam int FW     = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          r0_req = 1'b0, r0_we = 1'b0;
  logic [HW-1:0] r0_handle = '0;
  logic [FW-1:0] r0_field = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_req = 1'b0, r1_we = 1'b0;
  logic [HW-1:0] r1_handle = '0;
  logic [FW-1:0] r1_field = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          swap_req = 1'b0;
  logic [HW-1:0] swap_a = '0, swap_b = '0;

  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, swap_done, busy;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          n3_r0_gnt, n3_r0_rvalid, n3_r1_gnt, n3_r1_rvalid, n3_swap_done, n3_busy;
  logic [DW-1:0] n3_r0_rdata, n3_r1_rdata;
`ifdef KIWI_OBJBANK_STATS_EN
  logic [15:0]   conflict_cnt, swap_cnt, n3_conflict_cnt, n3_swap_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  kiwi_objbank_arbiter #(.NOBJ(NOBJ), .NFIELD(NFIELD), .DW(DW), .HW(HW), .FW(FW)) u_dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_handle(r0_handle), .r0_field(r0_field),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_handle(r1_handle), .r1_field(r1_field),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b), .swap_done(swap_done),
`ifdef KIWI_OBJBANK_STATS_EN
    .conflict_cnt(conflict_cnt), .swap_cnt(swap_cnt),
`endif
    .busy(busy)
  );

  kiwi_objbank_arbiter #(.NOBJ(NOBJ), .NFIELD(3), .DW(DW), .HW(HW), .FW(FW)) u_dut_n3 (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_handle(r0_handle), .r0_field(r0_field),
    .r0_wdata(r0_wdata), .r0_gnt(n3_r0_gnt), .r0_rvalid(n3_r0_rvalid), .r0_rdata(n3_r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_handle(r1_handle), .r1_field(r1_field),
    .r1_wdata(r1_wdata), .r1_gnt(n3_r1_gnt), .r1_rvalid(n3_r1_rvalid), .r1_rdata(n3_r1_rdata),
    .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b), .swap_done(n3_swap_done),
`ifdef KIWI_OBJBANK_STATS_EN
    .conflict_cnt(n3_conflict_cnt), .swap_cnt(n3_swap_cnt),
`endif
    .busy(n3_busy)
  );

  // ---------------------------------------------------------------- model
  logic [HW-1:0] m_map [NOBJ];
  logic [DW-1:0] m_mem [NOBJ][NFIELD];
  logic          m_last, m_swap, m_done;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [1:0]    mon_g;
  logic [DW-1:0] mon_d;

  // Expected {r1_gnt, r0_gnt} from current inputs and model state.
  function automatic logic [1:0] exp_gnt();
    logic [1:0] g;
    g = 2'b00;
    if (!m_swap && !(swap_req && !m_done)) begin
      if (r0_req && (!r1_req || m_last)) g[0] = 1'b1;
      else if (r1_req)                   g[1] = 1'b1;
    end
    return g;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [1:0]    g;
    logic          start;
    logic [HW-1:0] ph, tmp;
    if (reset) begin
      for (int i = 0; i < NOBJ; i++) begin
        m_map[i] = HW'(i);
        for (int j = 0; j < NFIELD; j++) m_mem[i][j] = '0;
      end
      m_last = 1'b1; m_swap = 1'b0; m_done = 1'b0;
      q0.delete(); q1.delete();
    end else begin
      g     = exp_gnt();
      start = !m_swap && swap_req && !m_done;
      if (g[0]) begin
        ph = m_map[r0_handle];
        if (r0_we) m_mem[ph][r0_field] = r0_wdata;
        else       q0.push_back(m_mem[ph][r0_field]);
        m_last = 1'b0;
      end
      if (g[1]) begin
        ph = m_map[r1_handle];
        if (r1_we) m_mem[ph][r1_field] = r1_wdata;
        else       q1.push_back(m_mem[ph][r1_field]);
        m_last = 1'b1;
      end
      m_done = m_swap;
      if (m_swap) begin
        tmp = m_map[swap_a];
        m_map[swap_a] = m_map[swap_b];
        m_map[swap_b] = tmp;
      end
      m_swap = start;
    end
  end

  // Grant / busy / swap_done monitor, mid low phase.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      mon_g = exp_gnt();
      n_total++;
      if ({r1_gnt, r0_gnt} !== mon_g) $display("FAIL gnt t=%0t: got %b expected %b", $time, {r1_gnt, r0_gnt}, mon_g);
      else n_pass++;
      n_total++;
      if (busy !== m_swap) $display("FAIL busy t=%0t: got %b expected %b", $time, busy, m_swap);
      else n_pass++;
      n_total++;
      if (swap_done !== m_done) $display("FAIL swap_done t=%0t: got %b expected %b", $time, swap_done, m_done);
      else n_pass++;
    end
  end

  // Read-return scoreboard.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      n_total++;
      if (q0.size() != 0) begin
        mon_d = q0.pop_front();
        if (r0_rvalid !== 1'b1 || r0_rdata !== mon_d)
          $display("FAIL r0_read t=%0t: got v=%b d=%0d expected v=1 d=%0d", $time, r0_rvalid, r0_rdata, mon_d);
        else n_pass++;
      end else if (r0_rvalid !== 1'b0) $display("FAIL r0_rvalid t=%0t: got %b expected 0", $time, r0_rvalid);
      else n_pass++;
      n_total++;
      if (q1.size() != 0) begin
        mon_d = q1.pop_front();
        if (r1_rvalid !== 1'b1 || r1_rdata !== mon_d)
          $display("FAIL r1_read t=%0t: got v=%b d=%0d expected v=1 d=%0d", $time, r1_rvalid, r1_rdata, mon_d);
        else n_pass++;
      end else if (r1_rvalid !== 1'b0) $display("FAIL r1_rvalid t=%0t: got %b expected 0", $time, r1_rvalid);
      else n_pass++;
    end
  end

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    n_total++;
    if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || r0_rdata !== '0 || r1_rdata !== '0)
      $display("FAIL reset_read: got v=%b%b d0=%0d d1=%0d expected all 0", r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || swap_done !== 1'b0)
      $display("FAIL reset_ctrl: got busy=%b done=%b expected 0 0", busy, swap_done);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk); r0_req = 1; r0_we = 1; r0_handle = 0; r0_field = 0; r0_wdata = 22;
    @(negedge clk); r0_handle = 1; r0_wdata = 32;
    @(negedge clk); r0_we = 0;
    #3;
    n_total++;
    if (r0_gnt !== 1'b1) $display("FAIL wr_read_gnt: got %b expected 1", r0_gnt);
    else n_pass++;
    @(negedge clk); r0_req = 0;
    #3;
    n_total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd32)
      $display("FAIL wr_read_data: got v=%b d=%0d expected v=1 d=32", r0_rvalid, r0_rdata);
    else n_pass++;
  endtask

  task automatic test_swap();
    @(negedge clk); swap_req = 1; swap_a = 0; swap_b = 1;
    @(negedge clk); #3;
    n_total++;
    if (busy !== 1'b1 || swap_done !== 1'b0) $display("FAIL swap_busy: got busy=%b done=%b expected 1 0", busy, swap_done);
    else n_pass++;
    @(negedge clk); #3;
    n_total++;
    if (busy !== 1'b0 || swap_done !== 1'b1) $display("FAIL swap_done_pulse: got busy=%b done=%b expected 0 1", busy, swap_done);
    else n_pass++;
    swap_req = 0;
    r0_req = 1; r0_we = 0; r0_handle = 0; r0_field = 0;
    @(negedge clk); r0_handle = 1;
    #3;
    n_total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd32) $display("FAIL swap_read_h0: got v=%b d=%0d expected v=1 d=32", r0_rvalid, r0_rdata);
    else n_pass++;
    @(negedge clk); r0_req = 0;
    #3;
    n_total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd22) $display("FAIL swap_read_h1: got v=%b d=%0d expected v=1 d=22", r0_rvalid, r0_rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); r0_req = 1; r0_we = 1; r0_handle = 0; r0_field = 2; r0_wdata = 55;
    @(negedge clk); r0_req = 0; r1_req = 1; r1_we = 1; r1_handle = 1; r1_field = 2; r1_wdata = 77;
    @(negedge clk); r0_req = 1; r0_we = 0; r1_we = 0;
    for (int i = 0; i < 6; i++) begin
      #3;
      n_total++;
      if (r0_gnt !== (i % 2 == 0) || r1_gnt !== (i % 2 == 1))
        $display("FAIL b2b_gnt[%0d]: got r1r0=%b%b expected r0 wins=%0d", i, r1_gnt, r0_gnt, (i % 2 == 0));
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (i % 2 == 1) begin
          if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd55 || r1_rvalid !== 1'b0)
            $display("FAIL b2b_ret[%0d]: got v0=%b d0=%0d v1=%b expected 1 55 0", i, r0_rvalid, r0_rdata, r1_rvalid);
          else n_pass++;
        end else begin
          if (r1_rvalid !== 1'b1 || r1_rdata !== 32'd77 || r0_rvalid !== 1'b0)
            $display("FAIL b2b_ret[%0d]: got v1=%b d1=%0d v0=%b expected 1 77 0", i, r1_rvalid, r1_rdata, r0_rvalid);
          else n_pass++;
        end
      end
      @(negedge clk);
    end
    r0_req = 0; r1_req = 0;
    #3;
    n_total++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 32'd77) $display("FAIL b2b_last: got v=%b d=%0d expected v=1 d=77", r1_rvalid, r1_rdata);
    else n_pass++;
  endtask

  task automatic test_field_bound();
    @(negedge clk); r0_req = 1; r0_we = 1; r0_handle = 0; r0_field = 3; r0_wdata = 1001;
    @(negedge clk); r0_we = 0;
    @(negedge clk); r0_req = 0;
    #3;
    n_total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd1001) $display("FAIL field3_rw: got v=%b d=%0d expected v=1 d=1001", r0_rvalid, r0_rdata);
    else n_pass++;
    n_total++;
    if (n3_r0_rvalid !== 1'b1 || n3_r0_rdata !== 32'd0) $display("FAIL field_oob: got v=%b d=%0d expected v=1 d=0", n3_r0_rvalid, n3_r0_rdata);
    else n_pass++;
  endtask

  task automatic test_swap_priority();
    @(negedge clk); swap_req = 1; swap_a = 0; swap_b = 1;
    r0_req = 1; r0_we = 0; r0_handle = 1; r0_field = 3;
    #3;
    n_total++;
    if (r0_gnt !== 1'b0) $display("FAIL prio_idle_gnt: got %b expected 0", r0_gnt);
    else n_pass++;
    @(negedge clk); #3;
    n_total++;
    if (r0_gnt !== 1'b0 || busy !== 1'b1) $display("FAIL prio_swap_gnt: got gnt=%b busy=%b expected 0 1", r0_gnt, busy);
    else n_pass++;
    @(negedge clk); #3;
    n_total++;
    if (r0_gnt !== 1'b1 || swap_done !== 1'b1) $display("FAIL prio_after_gnt: got gnt=%b done=%b expected 1 1", r0_gnt, swap_done);
    else n_pass++;
    swap_req = 0;
    @(negedge clk); r0_req = 0;
    #3;
    n_total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd1001) $display("FAIL prio_read: got v=%b d=%0d expected v=1 d=1001", r0_rvalid, r0_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_in_swap();
    @(negedge clk); swap_req = 1; swap_a = 0; swap_b = 1;
    @(negedge clk); #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL rst_swap_busy: got %b expected 1", busy);
    else n_pass++;
    reset = 1; swap_req = 0;
    #2;
    n_total++;
    if (busy !== 1'b0 || swap_done !== 1'b0) $display("FAIL rst_swap_abort: got busy=%b done=%b expected 0 0", busy, swap_done);
    else n_pass++;
    @(negedge clk); reset = 0;
    r0_req = 1; r0_we = 1; r0_handle = 0; r0_field = 1; r0_wdata = 32'hABCD;
    @(negedge clk); r0_we = 0;
    #3;
    n_total++;
    if (swap_done !== 1'b0) $display("FAIL rst_swap_nodone: got %b expected 0", swap_done);
    else n_pass++;
    @(negedge clk); r0_req = 0; r1_req = 1; r1_we = 0; r1_handle = 1; r1_field = 1;
    #3;
    n_total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hABCD) $display("FAIL rst_swap_read: got v=%b d=%0h expected v=1 d=abcd", r0_rvalid, r0_rdata);
    else n_pass++;
    @(negedge clk); r1_req = 0;
    #3;
    n_total++;
    if (r1_rvalid !== 1'b1 || r1_rdata !== 32'd0) $display("FAIL rst_swap_other: got v=%b d=%0h expected v=1 d=0", r1_rvalid, r1_rdata);
    else n_pass++;
  endtask

`ifdef KIWI_OBJBANK_STATS_EN
  task automatic test_stats();
    logic [15:0] c0, s0;
    @(negedge clk);
    c0 = conflict_cnt; s0 = swap_cnt;
    r0_req = 1; r0_we = 0; r0_field = 0; r1_req = 1; r1_we = 0; r1_field = 0;
    repeat (4) @(negedge clk);
    @(negedge clk); r0_req = 0; r1_req = 0;
    #3;
    n_total++;
    if (16'(conflict_cnt - c0) !== 16'd5) $display("FAIL stats_conflict: got %0d expected 5", 16'(conflict_cnt - c0));
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); swap_req = 1; swap_a = 0; swap_b = 1;
      @(negedge clk);
      @(negedge clk); swap_req = 0;
    end
    @(negedge clk); #3;
    n_total++;
    if (16'(swap_cnt - s0) !== 16'd3) $display("FAIL stats_swap: got %0d expected 3", 16'(swap_cnt - s0));
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_swap();
    test_back_to_back();
    test_field_bound();
    test_swap_priority();
    test_reset_in_swap();
`ifdef KIWI_OBJBANK_STATS_EN
    test_stats();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
